// File: rtl/i2c_target_regs.sv
// I2C target (slave) bridging bus transfers to a pointer/data register port.
// Optional spike filter on the synchronised SCL/SDA lines: define I2C_SPIKE_FILTER_EN.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h19,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RD_ACK    = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  // Edges are ignored until every pipeline stage holds a real bus sample.
  localparam int SETTLE_LEN = SYNC_STAGES + FILTER_LEN + 2;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_f, sda_f;

  // NOTE: synchronisers reset to 1 (idle bus level) so the first real samples
  // after reset do not look like a falling SDA/SCL edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_SPIKE_FILTER_EN
  logic [FILTER_LEN-2:0] scl_hist_q, sda_hist_q;
  logic [FILTER_LEN-1:0] scl_win, sda_win;
  logic                  scl_filt_q, sda_filt_q;

  assign scl_win = {scl_hist_q, scl_s};
  assign sda_win = {sda_hist_q, sda_s};

  // Output follows the input only once it has been stable for FILTER_LEN samples.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_win[FILTER_LEN-2:0];
      sda_hist_q <= sda_win[FILTER_LEN-2:0];
      if (&scl_win)       scl_filt_q <= 1'b1;
      else if (~|scl_win) scl_filt_q <= 1'b0;
      if (&sda_win)       sda_filt_q <= 1'b1;
      else if (~|sda_win) sda_filt_q <= 1'b0;
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  logic                  scl_q, sda_q;
  logic [SETTLE_LEN-1:0] settle_q;
  logic                  edge_en;
  logic                  scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      settle_q <= '0;
    end else begin
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      settle_q <= {settle_q[SETTLE_LEN-2:0], 1'b1};
    end
  end

  // START/STOP need SCL high on both samples, so an SDA change that coincides
  // with an SCL edge is never taken as a bus condition.
  assign edge_en   = settle_q[SETTLE_LEN-1];
  assign scl_rise  = edge_en &  scl_f & ~scl_q;
  assign scl_fall  = edge_en & ~scl_f &  scl_q;
  assign start_det = edge_en &  scl_f &  scl_q &  sda_q & ~sda_f;
  assign stop_det  = edge_en &  scl_f &  scl_q & ~sda_q &  sda_f;

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       rw_q;
  logic [7:0] shift_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values of its neighbours.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd7;
      byte_done <= 1'b0;
      rw_q      <= 1'b0;
      shift_q   <= '0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            shift_q <= {shift_q[6:0], sda_f};
            if (bit_cnt == 3'd0) byte_done <= 1'b1;
            else                 bit_cnt   <= bit_cnt - 3'd1;
          end
          S_RDATA: begin
            if (bit_cnt == 3'd0) byte_done <= 1'b1;
            else                 bit_cnt   <= bit_cnt - 3'd1;
          end
          S_ADDR_ACK:  reg_re <= rw_q;
          S_WDATA_ACK: reg_we <= 1'b1;
          S_RD_ACK: begin
            if (sda_f) begin
              state <= S_WAIT_STOP;
            end else begin
              reg_addr <= reg_addr + 8'd1;
              reg_re   <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          S_ADDR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              if (shift_q[7:1] == TARGET_ADDR) begin
                state  <= S_ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw_q   <= shift_q[0];
              end else begin
                state <= S_WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end
          S_PTR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              reg_addr  <= shift_q;
              state     <= S_PTR_ACK;
              sda_oe    <= 1'b1;
            end
          end
          S_WDATA: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              reg_wdata <= shift_q;
              state     <= S_WDATA_ACK;
              sda_oe    <= 1'b1;
            end
          end
          S_ADDR_ACK, S_RD_ACK: begin
            if (state == S_RD_ACK || rw_q) begin
              state   <= S_RDATA;
              bit_cnt <= 3'd7;
              shift_q <= reg_rdata;
              sda_oe  <= ~reg_rdata[7];
            end else begin
              state  <= S_PTR;
              sda_oe <= 1'b0;
            end
          end
          S_PTR_ACK: begin
            state  <= S_WDATA;
            sda_oe <= 1'b0;
          end
          S_WDATA_ACK: begin
            state    <= S_WDATA;
            sda_oe   <= 1'b0;
            reg_addr <= reg_addr + 8'd1;
          end
          S_RDATA: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              sda_oe    <= 1'b0;
              state     <= S_RD_ACK;
            end else begin
              shift_q <= {shift_q[6:0], 1'b0};
              sda_oe  <= ~shift_q[6];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master, register-file model and a
// strobe scoreboard fed by the stimulus and drained by an independent monitor.
module tb_i2c_target_regs;

  localparam int Q = 6;  // quarter SCL period in clk cycles (SCL = clk/24)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl, m_sda;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  always #5 clk = ~clk;

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;  // open-drain wired-AND

  i2c_target_regs dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .scl_in        (scl_in),
    .sda_in        (sda_in),
    .sda_oe        (sda_oe),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_rdata     (reg_rdata),
    .busy          (busy)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  mem [256];     // reference register file
  logic [15:0] exp_we_q[$];   // {addr, data}
  logic [7:0]  exp_re_q[$];   // addr
  logic [7:0]  wbytes[$];

  // Register file side: read data one clk after the request.
  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Strobe monitor: pops the scoreboard whenever the DUT issues a strobe.
  initial begin
    logic we_prev, re_prev;
    we_prev = 1'b0;
    re_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (reg_we || reg_re) check("we_re_exclusive", {31'd0, reg_we & reg_re}, 0);
        if (reg_we) begin
          check("we_width", {31'd0, we_prev}, 0);
          if (exp_we_q.size() == 0) check("we_spurious", {16'd0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
          else check("we_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, exp_we_q.pop_front()});
        end
        if (reg_re) begin
          check("re_width", {31'd0, re_prev}, 0);
          if (exp_re_q.size() == 0) check("re_spurious", {24'd0, reg_addr}, 32'hFFFF_FFFF);
          else check("re_addr", {24'd0, reg_addr}, {24'd0, exp_re_q.pop_front()});
        end
      end
      we_prev = reg_we;
      re_prev = reg_re;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); m_sda = b; tick(Q); m_scl = 1'b1; tick(2 * Q); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); b = sda_in; tick(Q); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic nak);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(nak);
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
  endtask

  task automatic end_txn(input string tag);
    bus_stop();
    tick(4);
    check({tag, "_busy_after_stop"}, {31'd0, busy}, 0);
    check({tag, "_sda_oe_after_stop"}, {31'd0, sda_oe}, 0);
  endtask

  // Pointer write followed by all bytes in wbytes, auto-incrementing with wrap.
  task automatic write_txn(input logic [7:0] ptr);
    logic       nak;
    logic [7:0] a;
    bus_start();
    send_byte(8'h32, nak);
    check("wr_addr_ack", {31'd0, nak}, 0);
    check("wr_busy_after_match", {31'd0, busy}, 1);
    send_byte(ptr, nak);
    check("wr_ptr_ack", {31'd0, nak}, 0);
    a = ptr;
    foreach (wbytes[i]) begin
      exp_we_q.push_back({a, wbytes[i]});
      mem[a] = wbytes[i];
      send_byte(wbytes[i], nak);
      check("wr_data_ack", {31'd0, nak}, 0);
      a = a + 8'd1;
    end
    end_txn("wr");
    check("wr_all_strobes_seen", exp_we_q.size(), 0);
  endtask

  // Pointer write, repeated START, read n bytes (ACK all but the last).
  task automatic read_txn(input logic [7:0] ptr, input int n);
    logic       nak;
    logic [7:0] a, d;
    bus_start();
    send_byte(8'h32, nak);
    check("rd_waddr_ack", {31'd0, nak}, 0);
    send_byte(ptr, nak);
    check("rd_ptr_ack", {31'd0, nak}, 0);
    bus_start();
    exp_re_q.push_back(ptr);
    send_byte(8'h33, nak);
    check("rd_raddr_ack", {31'd0, nak}, 0);
    a = ptr;
    for (int i = 0; i < n; i++) begin
      recv_byte(d);
      check("rd_data", {24'd0, d}, {24'd0, mem[a]});
      a = a + 8'd1;
      if (i < n - 1) begin
        exp_re_q.push_back(a);
        send_bit(1'b0);
      end else begin
        send_bit(1'b1);
        tick(2);
        check("rd_sda_released_after_nack", {31'd0, sda_oe}, 0);
        check("rd_busy_held_after_nack", {31'd0, busy}, 1);
      end
    end
    end_txn("rd");
    check("rd_all_strobes_seen", exp_re_q.size(), 0);
  endtask

  initial begin
    logic       nak, b;
    logic [7:0] ptr, bad;
    int         n;

    m_scl = 1'b1;
    m_sda = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    tick(3);
    check("rst_sda_oe", {31'd0, sda_oe}, 0);
    check("rst_reg_addr", {24'd0, reg_addr}, 0);
    check("rst_reg_wdata", {24'd0, reg_wdata}, 0);
    check("rst_reg_we", {31'd0, reg_we}, 0);
    check("rst_reg_re", {31'd0, reg_re}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    tick(20);

    wbytes = '{8'hAB, 8'hCD};
    write_txn(8'h10);

    mem[8'h0F] = 8'h33;
    mem[8'h10] = 8'h44;
    read_txn(8'h0F, 2);

    // Foreign address: no ACK anywhere, no strobes, not busy.
    bus_start();
    send_byte(8'h50, nak);
    check("bad_addr_nak", {31'd0, nak}, 1);
    check("bad_addr_busy", {31'd0, busy}, 0);
    send_byte(8'h12, nak);
    check("bad_addr_data_nak", {31'd0, nak}, 1);
    end_txn("bad");

    do bad = {1'($urandom), 7'($urandom)}; while (bad[7:1] == 7'h19);
    bus_start();
    send_byte(bad, nak);
    check("rand_bad_addr_nak", {31'd0, nak}, 1);
    end_txn("rbad");

    wbytes = '{8'h5A, 8'hA5};
    write_txn(8'hFF);
    read_txn(8'hFF, 2);

    // STOP after half a data byte: no write.
    bus_start();
    send_byte(8'h32, nak);
    send_byte(8'h20, nak);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    end_txn("partial");
    wbytes = '{8'h77};
    write_txn(8'h21);

    // Reset asserted while the target drives a read byte.
    mem[8'h40] = 8'h00;
    bus_start();
    send_byte(8'h32, nak);
    send_byte(8'h40, nak);
    bus_start();
    exp_re_q.push_back(8'h40);
    send_byte(8'h33, nak);
    for (int i = 0; i < 3; i++) recv_bit(b);
    tick(2);
    check("mid_read_driving", {31'd0, sda_oe}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_read_rst_sda_oe", {31'd0, sda_oe}, 0);
    check("mid_read_rst_busy", {31'd0, busy}, 0);
    check("mid_read_rst_addr", {24'd0, reg_addr}, 0);
    tick(3);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    wbytes = '{8'h3C, 8'hC3, 8'h99};
    write_txn(8'h80);
    read_txn(8'h80, 3);

    // One-clk SDA glitch while SCL is high inside a byte.
    bus_start();
    send_byte(8'h32, nak);
    check("glitch_addr_ack", {31'd0, nak}, 0);
    tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(1); m_sda = 1'b0; tick(Q);
`ifdef I2C_SPIKE_FILTER_EN
    check("glitch_busy", {31'd0, busy}, 1);
`else
    check("glitch_busy", {31'd0, busy}, 0);
`endif
    m_scl = 1'b0;
    end_txn("glitch");

    for (int t = 0; t < 6; t++) begin
      ptr = 8'($urandom);
      n = int'($urandom_range(1, 4));
      wbytes.delete();
      for (int i = 0; i < n; i++) wbytes.push_back(8'($urandom));
      write_txn(ptr);
      read_txn(ptr, int'($urandom_range(1, 5)));
    end

    tick(10);
    check("final_we_queue_empty", exp_we_q.size(), 0);
    check("final_re_queue_empty", exp_re_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
